// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioner: debounce state encodings
// and the default debounce interval for a 50 MHz clock.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED        = 2'd0,
        ST_CONFIRM_PRESS   = 2'd1,
        ST_PRESSED         = 2'd2,
        ST_CONFIRM_RELEASE = 2'd3
    } db_state_e;

    // 10 ms of stable input at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: two-flop synchroniser feeding a debounce FSM that
// produces a registered active-low level and one-cycle press/release strobes.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic CLK_50MHz,
    input  logic reset_n,
    input  logic raw_n,
    output logic level_n,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_r;
    logic             s2_r;
    db_state_e        state_r;
    db_state_e        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             level_n_r;
    logic             level_n_nxt_s;
    logic             press_r;
    logic             press_nxt_s;
    logic             release_r;
    logic             release_nxt_s;

    // Synchroniser; idles high so an unpressed button is seen during reset release
    always_ff @(posedge CLK_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            s1_r <= 1'b1;
            s2_r <= 1'b1;
        end else begin
            s1_r <= raw_n;
            s2_r <= s1_r;
        end
    end

    // FSM, counter and registered outputs
    always_ff @(posedge CLK_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_RELEASED;
            cnt_r     <= '0;
            level_n_r <= 1'b1;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            level_n_r <= level_n_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
        end
    end

    // Next-state logic; any deviation from the candidate level restarts the count
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        level_n_nxt_s = level_n_r;
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        case (state_r)
            ST_RELEASED: begin
                if (!s2_r) begin
                    state_nxt_s = ST_CONFIRM_PRESS;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_RELEASED;
                end
            end
            ST_CONFIRM_PRESS: begin
                if (s2_r) begin
                    state_nxt_s = ST_RELEASED;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s   = ST_PRESSED;
                    cnt_nxt_s     = '0;
                    level_n_nxt_s = 1'b0;
                    press_nxt_s   = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (s2_r) begin
                    state_nxt_s = ST_CONFIRM_RELEASE;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_PRESSED;
                end
            end
            ST_CONFIRM_RELEASE: begin
                if (!s2_r) begin
                    state_nxt_s = ST_PRESSED;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s   = ST_RELEASED;
                    cnt_nxt_s     = '0;
                    level_n_nxt_s = 1'b1;
                    release_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s   = ST_RELEASED;
                cnt_nxt_s     = '0;
                level_n_nxt_s = 1'b1;
            end
        endcase
    end

    assign level_n       = level_n_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton conditioner: NUM_BTNS independent synchronise-and-debounce
// channels (bit 0 start_stop, bit 1 hold, bit 2 spare/lap).
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NUM_BTNS        = 3,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                CLK_50MHz,
    input  logic                reset_n,
    input  logic [NUM_BTNS-1:0] btn_raw_n,
    output logic [NUM_BTNS-1:0] btn_level_n,
    output logic [NUM_BTNS-1:0] press_pulse,
    output logic [NUM_BTNS-1:0] release_pulse
);

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .CLK_50MHz    (CLK_50MHz),
            .reset_n      (reset_n),
            .raw_n        (btn_raw_n[g]),
            .level_n      (btn_level_n[g]),
            .press_pulse  (press_pulse[g]),
            .release_pulse(release_pulse[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: run-length reference model
// compared every cycle, plus hand-computed checkpoints for the directed cases.
module tb_button_conditioner;

    localparam int N = 3;
    localparam int D = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw   = 3'b000;
    logic [N-1:0] level_n;
    logic [N-1:0] press;
    logic [N-1:0] rel;

    int tests = 0;
    int fails = 0;

    button_conditioner #(
        .NUM_BTNS       (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .CLK_50MHz    (clk),
        .reset_n      (rst_n),
        .btn_raw_n    (raw),
        .btn_level_n  (level_n),
        .press_pulse  (press),
        .release_pulse(rel)
    );

    always #10 clk = ~clk;

    // Model: level flips once the synchronised input has disagreed with it
    // for D+1 consecutive samples (entry sample plus D counted samples).
    logic [N-1:0] m_s1, m_s2, m_level, m_press, m_rel;
    int           m_run [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1    <= 3'b111;
            m_s2    <= 3'b111;
            m_level <= 3'b111;
            m_press <= 3'b000;
            m_rel   <= 3'b000;
            for (int i = 0; i < N; i++) m_run[i] <= 0;
        end else begin
            m_s1 <= raw;
            m_s2 <= m_s1;
            for (int i = 0; i < N; i++) begin
                m_press[i] <= 1'b0;
                m_rel[i]   <= 1'b0;
                if (m_s2[i] == m_level[i]) begin
                    m_run[i] <= 0;
                end else if (m_run[i] + 1 == D + 1) begin
                    m_level[i] <= m_s2[i];
                    m_press[i] <= ~m_s2[i];
                    m_rel[i]   <= m_s2[i];
                    m_run[i]   <= 0;
                end else begin
                    m_run[i] <= m_run[i] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-computed expectations applied to both the DUT and the model
    task automatic check_lit(input string name, input logic [N-1:0] lv, input logic [N-1:0] pr,
                             input logic [N-1:0] rl);
        check({name, "_level"}, level_n, lv);
        check({name, "_press"}, press, pr);
        check({name, "_release"}, rel, rl);
        check({name, "_model_level"}, m_level, lv);
        check({name, "_model_press"}, m_press, pr);
        check({name, "_model_release"}, m_rel, rl);
    endtask

    // Returns on the falling edge after n rising edges
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check("cyc_level", level_n, m_level);
        check("cyc_press", press, m_press);
        check("cyc_release", rel, m_rel);
    end

    initial begin
        logic [N-1:0] sticky;
        logic         bounce_pat [7];
        bounce_pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset with all buttons pressed
        wait_edges(3);
        check_lit("reset", 3'b111, 3'b000, 3'b000);
        raw   = 3'b111;
        rst_n = 1'b1;
        wait_edges(4);

        // Clean press on channel 0: accepted on edge k+6
        raw = 3'b110;
        wait_edges(6);
        check_lit("press_early", 3'b111, 3'b000, 3'b000);
        wait_edges(1);
        check_lit("press_edge", 3'b110, 3'b001, 3'b000);
        wait_edges(1);
        check_lit("press_after", 3'b110, 3'b000, 3'b000);

        // Clean release on channel 0
        raw = 3'b111;
        wait_edges(6);
        check_lit("rel_early", 3'b110, 3'b000, 3'b000);
        wait_edges(1);
        check_lit("rel_edge", 3'b111, 3'b000, 3'b001);
        wait_edges(1);
        check_lit("rel_after", 3'b111, 3'b000, 3'b000);

        // Bounce on channel 1: low 3, high 1, low 3, then high
        sticky = 3'b000;
        for (int i = 0; i < 7; i++) begin
            raw[1] = bounce_pat[i];
            wait_edges(1);
            sticky = sticky | press | rel;
        end
        raw[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_edges(1);
            sticky = sticky | press | rel;
        end
        check("bounce_pulses", sticky, 3'b000);
        check_lit("bounce_end", 3'b111, 3'b000, 3'b000);

        // Simultaneous press on channels 0 and 2
        raw = 3'b010;
        wait_edges(6);
        check_lit("simul_early", 3'b111, 3'b000, 3'b000);
        wait_edges(1);
        check_lit("simul_edge", 3'b010, 3'b101, 3'b000);
        wait_edges(1);
        check_lit("simul_after", 3'b010, 3'b000, 3'b000);
        raw = 3'b111;
        wait_edges(7);
        check_lit("simul_release", 3'b111, 3'b000, 3'b101);
        wait_edges(2);

        // Reset while channel 0 is held, then re-acceptance
        raw = 3'b110;
        wait_edges(8);
        check_lit("held_before_rst", 3'b110, 3'b000, 3'b000);
        #2 rst_n = 1'b0;
        wait_edges(2);
        check_lit("held_in_rst", 3'b111, 3'b000, 3'b000);
        rst_n = 1'b1;
        wait_edges(6);
        check_lit("rearm_early", 3'b111, 3'b000, 3'b000);
        wait_edges(1);
        check_lit("rearm_edge", 3'b110, 3'b001, 3'b000);
        wait_edges(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
